pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_generator.sv | 77 +++++++
 tb/tb_pwm_generator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// Edge-programmable PWM: window [LEFT,RIGHT) against an external period counter, with optional wrap (OVER).
// Optional build macro PWM_GEN_CYCLE_GUARD_EN: suppresses output outside CYCLE and clamps edges to CYCLE.
module pwm_generator #(
    parameter int WIDTH = 13
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] TIME_CNT,
    input  logic [WIDTH-1:0] CYCLE,
    input  logic             OVER,
    input  logic [WIDTH-1:0] LEFT,
    input  logic [WIDTH-1:0] RIGHT,
    output logic             PWM_OUT
);

    logic [WIDTH-1:0] l_s_q, l_s_d;
    logic [WIDTH-1:0] r_s_q, r_s_d;
    logic             o_s_q, o_s_d;
    logic             pwm_q, pwm_d;

    logic             period_start;
    logic [WIDTH-1:0] eff_l;
    logic [WIDTH-1:0] eff_r;
    logic             eff_o;
    logic             hit;

    // Period start uses the live inputs so a new window applies from its very first count.
    always_comb begin
        period_start = (TIME_CNT == '0);
        eff_l        = period_start ? LEFT  : l_s_q;
        eff_r        = period_start ? RIGHT : r_s_q;
        eff_o        = period_start ? OVER  : o_s_q;

`ifdef PWM_GEN_CYCLE_GUARD_EN
        if (eff_l > CYCLE) eff_l = CYCLE;
        if (eff_r > CYCLE) eff_r = CYCLE;
`endif

        if (eff_o) begin
            hit = (TIME_CNT < eff_r) || (TIME_CNT >= eff_l);
        end else begin
            hit = (TIME_CNT >= eff_l) && (TIME_CNT < eff_r);
        end

`ifdef PWM_GEN_CYCLE_GUARD_EN
        if (TIME_CNT >= CYCLE) hit = 1'b0;
`endif

        l_s_d = period_start ? LEFT  : l_s_q;
        r_s_d = period_start ? RIGHT : r_s_q;
        o_s_d = period_start ? OVER  : o_s_q;
        pwm_d = hit;
    end

`ifndef PWM_GEN_CYCLE_GUARD_EN
    // CYCLE only matters to the guarded build.
    logic unused_cycle;
    assign unused_cycle = ^CYCLE;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            l_s_q <= '0;
            r_s_q <= '0;
            o_s_q <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            l_s_q <= l_s_d;
            r_s_q <= r_s_d;
            o_s_q <= o_s_d;
            pwm_q <= pwm_d;
        end
    end

    assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: the bench sweeps TIME_CNT itself and checks per-period pulse statistics.
module tb_pwm_generator;

    localparam int WIDTH = 13;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic [WIDTH-1:0] TIME_CNT = '0;
    logic [WIDTH-1:0] CYCLE = 13'd5000;
    logic             OVER = 1'b0;
    logic [WIDTH-1:0] LEFT = '0;
    logic [WIDTH-1:0] RIGHT = '0;
    logic             PWM_OUT;

    int n_checks = 0;
    int n_fails  = 0;
    int prev_out = 0;
    int hi_cnt, rises, first_hi, first_lo;

    pwm_generator #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TIME_CNT(TIME_CNT),
        .CYCLE   (CYCLE),
        .OVER    (OVER),
        .LEFT    (LEFT),
        .RIGHT   (RIGHT),
        .PWM_OUT (PWM_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one counter value; afterwards PWM_OUT is the registered result for it.
    task automatic tick(input int tc);
        TIME_CNT = tc[WIDTH-1:0];
        @(posedge CLK);
        #1;
        if (PWM_OUT === 1'b1 && prev_out == 0) rises++;
        prev_out = (PWM_OUT === 1'b1) ? 1 : 0;
    endtask

    // One full period; optionally reprograms LEFT/RIGHT just before count chg_at.
    task automatic run_period(input int cyc, input int chg_at, input int nl, input int nr);
        hi_cnt = 0; rises = 0; first_hi = -1; first_lo = -1;
        for (int t = 0; t < cyc; t++) begin
            if (t == chg_at) begin
                LEFT  = nl[WIDTH-1:0];
                RIGHT = nr[WIDTH-1:0];
            end
            tick(t);
            if (PWM_OUT === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = t;
            end else if (first_hi >= 0 && first_lo < 0) begin
                first_lo = t;
            end
        end
        $display("period cyc=%0d L=%0d R=%0d O=%0d: high=%0d rises=%0d first_hi=%0d first_lo=%0d",
                 cyc, LEFT, RIGHT, OVER, hi_cnt, rises, first_hi, first_lo);
    endtask

    initial begin
        int rest_hi;

        // Reset holds output low even with a window covering the counter.
        LEFT = 13'd0; RIGHT = 13'd100; OVER = 1'b0;
        tick(5);
        check("reset_out", int'(PWM_OUT), 0);
        tick(6);
        check("reset_out2", int'(PWM_OUT), 0);
        // Released mid-period: cleared shadows keep output low until TIME_CNT==0.
        RESET_N = 1'b1;
        tick(7);
        check("post_reset_low_a", int'(PWM_OUT), 0);
        tick(8);
        check("post_reset_low_b", int'(PWM_OUT), 0);

        // 50% window
        CYCLE = 13'd5000; LEFT = 13'd1250; RIGHT = 13'd3750; OVER = 1'b0;
        rises = 0;
        run_period(5000, -1, 0, 0);
        check("w50_high", hi_cnt, 2500);
        check("w50_rises", rises, 1);
        check("w50_first_hi", first_hi, 1250);
        check("w50_first_lo", first_lo, 3750);

        // Wrapped window
        LEFT = 13'd4750; RIGHT = 13'd2250; OVER = 1'b1;
        run_period(5000, -1, 0, 0);
        check("wrap_p1_high", hi_cnt, 2500);
        check("wrap_p1_rises", rises, 2);
        run_period(5000, -1, 0, 0);
        check("wrap_p2_high", hi_cnt, 2500);
        check("wrap_p2_rises", rises, 1);
        check("wrap_p2_first_hi", first_hi, 0);
        check("wrap_p2_first_lo", first_lo, 2250);
        check("wrap_p2_end_high", int'(PWM_OUT), 1);

        // Mid-period reprogramming only affects the next period
        LEFT = 13'd1250; RIGHT = 13'd3750; OVER = 1'b0;
        run_period(5000, 2000, 500, 3000);
        check("chg_p1_high", hi_cnt, 2500);
        check("chg_p1_rises", rises, 1);
        check("chg_p1_first_hi", first_hi, 1250);
        check("chg_p1_first_lo", first_lo, 3750);
        run_period(5000, -1, 0, 0);
        check("chg_p2_high", hi_cnt, 2500);
        check("chg_p2_rises", rises, 1);
        check("chg_p2_first_hi", first_hi, 500);
        check("chg_p2_first_lo", first_lo, 3000);

        // Degenerate L==R
        LEFT = 13'd2000; RIGHT = 13'd2000; OVER = 1'b0;
        run_period(5000, -1, 0, 0);
        check("eq_o0_high", hi_cnt, 0);
        check("eq_o0_rises", rises, 0);
        OVER = 1'b1;
        run_period(5000, -1, 0, 0);
        check("eq_o1_high", hi_cnt, 5000);
        check("eq_o1_rises", rises, 1);

        // Single-clock pulse and its move by one count
        CYCLE = 13'd10; LEFT = 13'd0; RIGHT = 13'd1; OVER = 1'b0;
        run_period(10, -1, 0, 0);
        check("p0_high", hi_cnt, 1);
        check("p0_first_hi", first_hi, 0);
        check("p0_first_lo", first_lo, 1);
        LEFT = 13'd1; RIGHT = 13'd2;
        run_period(10, -1, 0, 0);
        check("p1_high", hi_cnt, 1);
        check("p1_first_hi", first_hi, 1);
        check("p1_rises", rises, 1);

        // Reset mid-pulse
        CYCLE = 13'd5000; LEFT = 13'd1250; RIGHT = 13'd3750; OVER = 1'b0;
        for (int t = 0; t < 2000; t++) tick(t);
        check("rst_pre_high", int'(PWM_OUT), 1);
        RESET_N = 1'b0;
        for (int t = 2000; t < 2003; t++) begin
            tick(t);
            check($sformatf("rst_low_%0d", t), int'(PWM_OUT), 0);
        end
        RESET_N = 1'b1;
        rest_hi = 0;
        for (int t = 2003; t < 5000; t++) begin
            tick(t);
            if (PWM_OUT === 1'b1) rest_hi++;
        end
        check("rst_rest_high", rest_hi, 0);
        rises = 0;
        run_period(5000, -1, 0, 0);
        check("rst_next_high", hi_cnt, 2500);
        check("rst_next_first_hi", first_hi, 1250);
        check("rst_next_rises", rises, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
